amm_burst_driver: RTL

// - Avalon-MM master stage upstream of measure_block: turns test commands into AMM write bursts / read requests.
// - Its read_o/write_o/burstcount_o/byteenable_o/waitrequest_i/readdatavalid_i are the exact signals measure_block taps.
// - Limits outstanding read bursts to the number of delay counters measure_block owns.

---
 rtl/amm_burst_driver_pkg.sv | 18 +
 rtl/amm_burst_driver_if.sv | 36 +++
 rtl/amm_burst_driver_len_fifo.sv | 57 +++++
 rtl/amm_burst_driver.sv | 102 ++++++++++
 4 files changed

// File: rtl/amm_burst_driver_pkg.sv
// Shared Avalon-MM settings and the command record used by the burst driver.
package rtl_settings_pkg;

  localparam int AMM_ADDR_W   = 32;
  localparam int AMM_DATA_W   = 128;
  localparam int AMM_BURST_W  = 11;
  localparam int DATA_B_W     = AMM_DATA_W / 8;
  localparam int MAX_RD_OUTST = 4;

  typedef struct packed {
    logic                   write;
    logic [AMM_ADDR_W-1:0]  address;
    logic [AMM_BURST_W-1:0] burstcount;
    logic [AMM_DATA_W-1:0]  data;
    logic [DATA_B_W-1:0]    byteenable;
  } amm_cmd_t;

endpackage

// File: rtl/amm_burst_driver_if.sv
// Command handshake plus Avalon-MM master signals of the burst driver.
interface amm_burst_driver_if;
  import rtl_settings_pkg::*;

  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic                   cmd_write_i;
  logic [AMM_ADDR_W-1:0]  cmd_address_i;
  logic [AMM_BURST_W-1:0] cmd_burstcount_i;
  logic [AMM_DATA_W-1:0]  cmd_data_i;
  logic [DATA_B_W-1:0]    cmd_byteenable_i;

  logic [AMM_ADDR_W-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic [AMM_BURST_W-1:0] burstcount_o;
  logic [DATA_B_W-1:0]    byteenable_o;
  logic [AMM_DATA_W-1:0]  writedata_o;
  logic                   waitrequest_i;
  logic                   readdatavalid_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_address_i, cmd_burstcount_i,
           cmd_data_i, cmd_byteenable_i, waitrequest_i, readdatavalid_i,
    output cmd_ready_o, address_o, read_o, write_o, burstcount_o,
           byteenable_o, writedata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_address_i, cmd_burstcount_i,
           cmd_data_i, cmd_byteenable_i, waitrequest_i, readdatavalid_i,
    input  cmd_ready_o, address_o, read_o, write_o, burstcount_o,
           byteenable_o, writedata_o
  );

endinterface

// File: rtl/amm_burst_driver_len_fifo.sv
// Lengths of outstanding read bursts; the head entry is counted down by readdatavalid.
module burst_len_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] push_len_i,
  input  logic         rdv_i,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic [W-1:0]  head_q, head_rem;
  logic          head_vld_q;
  logic          take, pop;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == (PW+1)'(DEPTH));
  // Until the first word of a burst arrives, the remaining count is the FIFO head itself.
  assign head_rem = head_vld_q ? head_q : mem_q[rd_ptr_q];
  assign take     = rdv_i && !empty_o;
  assign pop      = take && (head_rem == W'(1));

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_len_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: ;
      endcase
      if (take) begin
        head_vld_q <= !pop;
        head_q     <= head_rem - W'(1);
      end
    end
  end

endmodule

// File: rtl/amm_burst_driver.sv
// Avalon-MM master: turns commands into write bursts or read requests and
// throttles reads to the number of bursts the downstream monitor can track.
module amm_burst_driver
  import rtl_settings_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  amm_burst_driver_if.master bus,
  output logic               busy_o,
  output logic               cmd_err_o
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_REQ} state_e;

  state_e                 state_q, state_d;
  amm_cmd_t               cmd_q, cmd_d;
  logic [AMM_BURST_W-1:0] beat_q, beat_d;
  logic                   err_q, err_d;
  logic                   busy_q;
  logic                   accept, push, rd_full, rd_empty;

  burst_len_fifo #(
    .DEPTH (MAX_RD_OUTST),
    .W     (AMM_BURST_W)
  ) u_len_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (push),
    .push_len_i (cmd_q.burstcount),
    .rdv_i      (bus.readdatavalid_i),
    .full_o     (rd_full),
    .empty_o    (rd_empty)
  );

  // Writes also wait for a free read slot so command order is never reshuffled.
  assign bus.cmd_ready_o  = (state_q == IDLE) && !rd_full;
  assign accept           = bus.cmd_valid_i && bus.cmd_ready_o;

  assign bus.write_o      = (state_q == WR_BURST);
  assign bus.read_o       = (state_q == RD_REQ);
  assign bus.address_o    = cmd_q.address;
  assign bus.burstcount_o = cmd_q.burstcount;
  assign bus.byteenable_o = cmd_q.byteenable;
  assign bus.writedata_o  = cmd_q.data + AMM_DATA_W'(beat_q);
  assign busy_o           = busy_q;
  assign cmd_err_o        = err_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_burstcount_i == '0) begin
            err_d = 1'b1;
          end else begin
            cmd_d.write      = bus.cmd_write_i;
            cmd_d.address    = bus.cmd_address_i;
            cmd_d.burstcount = bus.cmd_burstcount_i;
            cmd_d.data       = bus.cmd_data_i;
            cmd_d.byteenable = bus.cmd_byteenable_i;
            beat_d           = '0;
            state_d          = bus.cmd_write_i ? WR_BURST : RD_REQ;
          end
        end
      end
      WR_BURST: begin
        if (!bus.waitrequest_i) begin
          if (beat_q == cmd_q.burstcount - AMM_BURST_W'(1)) state_d = IDLE;
          else                                              beat_d  = beat_q + AMM_BURST_W'(1);
        end
      end
      RD_REQ: begin
        if (!bus.waitrequest_i) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      busy_q  <= (state_q != IDLE) || !rd_empty;
    end
  end

endmodule
